// File: rtl/mem_write_b_ctrl_pkg.sv
// Shared types for the B-operand buffer write controller.
// Latency: n/a (types only).
// Backpressure: n/a.
// Holds the controller FSM state encoding and the input stream order encoding.
package mem_ctrl_pkg;

  typedef enum logic [1:0] {IDLE, WRITE, DONE} wr_state_t;

  typedef enum logic {ROW_MAJOR, COL_MAJOR} wr_mode_t;

endpackage

// File: rtl/mem_write_b_ctrl_if.sv
// Stream-in / bank-write-out bundle of the B-buffer write controller.
// Latency: n/a (wires only).
// Backpressure: bank_ready gates s_ready inside the controller.
// Ports: s_valid/s_ready (DMA beat handshake), bank_ready (bank ports free),
//        wr_en/wr_addr_B/activate_B (bank write strobe, address, one-hot bank select).
// The master modport is the controller; the slave modport is the DMA/bank side.
interface mem_write_b_ctrl_if #(
  parameter int N2     = 4,
  parameter int ADDR_W = 12
);

  logic              s_valid;
  logic              s_ready;
  logic              bank_ready;
  logic              wr_en;
  logic [ADDR_W-1:0] wr_addr_B;
  logic [N2-1:0]     activate_B;

  modport master (
    input  s_valid, bank_ready,
    output s_ready, wr_en, wr_addr_B, activate_B
  );

  modport slave (
    output s_valid, bank_ready,
    input  s_ready, wr_en, wr_addr_B, activate_B
  );

endinterface

// File: rtl/mem_write_b_ctrl_wrap_counter.sv
// Wrapping up-counter: adds step when enabled, returns to zero after reaching limit.
// Latency: value updates the cycle after en; wrap is combinational on the current value.
// Backpressure: none; holds whenever en is low.
// Ports: clk, rst (sync, active-high), clr (sync clear), en (advance), step, limit,
//        value (current count), wrap (value is at limit, i.e. the next advance wraps).
module wrap_counter #(
  parameter int W = 16
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         clr,
  input  logic         en,
  input  logic [W-1:0] step,
  input  logic [W-1:0] limit,
  output logic [W-1:0] value,
  output logic         wrap
);

  assign wrap = (value == limit);

  always_ff @(posedge clk) begin
    if (rst || clr) begin
      value <= '0;
    end else if (en) begin
      value <= wrap ? '0 : value + step;
    end
  end

endmodule

// File: rtl/mem_write_b_ctrl.sv
// Spreads a streamed M2 x (N2*M3dN2) B matrix over N2 column banks, ping-ponging buffers.
// Latency: one cycle from an accepted beat to its bank write strobe.
// Backpressure: s_ready = WRITE & bank_ready; counters hold while no beat is accepted.
// Ports: clk, rst (sync, active-high); start/mode/M2/M3dN2 (matrix launch, latched in IDLE);
//        bus (master: s_valid/s_ready in, wr_en/wr_addr_B/activate_B out, bank_ready in);
//        busy (WRITE or DONE), done (one-cycle end pulse), buf_sel (buffer being written).
module mem_write_b_ctrl
  import mem_ctrl_pkg::*;
#(
  parameter int N2           = 4,
  parameter int MATRIXSIZE_W = 16,
  parameter int ADDR_W       = 12,
  parameter int P_B          = 1,
  parameter int NBUF         = 2,
  parameter int BUF_OFFSET   = 2048
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    start,
  input  logic                    mode,
  input  logic [MATRIXSIZE_W-1:0] M2,
  input  logic [MATRIXSIZE_W-1:0] M3dN2,
  mem_write_b_ctrl_if.master      bus,
  output logic                    busy,
  output logic                    done,
  output logic                    buf_sel
);

  localparam int W = MATRIXSIZE_W;

  wr_state_t   state, state_nxt;
  wr_mode_t    mode_q;
  logic [W-1:0] m2_q, m3_q;

  logic        s_ready_c, fire, start_acc, last_beat;
  logic        col_en, phase_en, row_en;
  logic        col_wrap, phase_wrap, row_wrap;
  logic [W-1:0] col_v, phase_v, row_v;
  logic [ADDR_W-1:0] phase_off;
  logic [ADDR_W-1:0] base;

  logic              wr_en_q;
  logic [ADDR_W-1:0] wr_addr_q;
  logic [N2-1:0]     act_q;

  assign start_acc = (state == IDLE) && start;
  assign fire      = bus.s_valid && s_ready_c;
  assign last_beat = row_wrap && col_wrap && phase_wrap;

  // ---------------- FSM: state register ----------------
  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  // ---------------- FSM: next state ----------------
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:  if (start) state_nxt = ((M2 == '0) || (M3dN2 == '0)) ? DONE : WRITE;
      WRITE: if (fire && last_beat) state_nxt = DONE;
      DONE:  state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // ---------------- FSM: outputs ----------------
  always_comb begin
    s_ready_c = 1'b0;
    busy      = 1'b0;
    done      = 1'b0;
    case (state)
      WRITE: begin
        s_ready_c = bus.bank_ready;
        busy      = 1'b1;
      end
      DONE: begin
        busy = 1'b1;
        done = 1'b1;
      end
      default: ;
    endcase
  end

  assign bus.s_ready = s_ready_c;

  // Sizes and order are captured once so the stream sees stable geometry.
  always_ff @(posedge clk) begin
    if (rst) begin
      mode_q <= ROW_MAJOR;
      m2_q   <= '0;
      m3_q   <= '0;
    end else if (start_acc) begin
      mode_q <= wr_mode_t'(mode);
      m2_q   <= M2;
      m3_q   <= M3dN2;
    end
  end

  // Row-major input walks banks fastest; column-major walks rows fastest.
  always_comb begin
    col_en   = 1'b0;
    phase_en = 1'b0;
    row_en   = 1'b0;
    if (mode_q == ROW_MAJOR) begin
      col_en   = fire;
      phase_en = fire && col_wrap;
      row_en   = fire && col_wrap && phase_wrap;
    end else begin
      row_en   = fire;
      col_en   = fire && row_wrap;
      phase_en = fire && row_wrap && col_wrap;
    end
  end

  wrap_counter #(.W(W)) u_col (
    .clk(clk), .rst(rst), .clr(start_acc), .en(col_en),
    .step(W'(1)), .limit(W'(N2 - 1)), .value(col_v), .wrap(col_wrap)
  );

  wrap_counter #(.W(W)) u_phase (
    .clk(clk), .rst(rst), .clr(start_acc), .en(phase_en),
    .step(W'(1)), .limit(m3_q - W'(1)), .value(phase_v), .wrap(phase_wrap)
  );

  wrap_counter #(.W(W)) u_row (
    .clk(clk), .rst(rst), .clr(start_acc), .en(row_en),
    .step(W'(P_B)), .limit(m2_q - W'(P_B)), .value(row_v), .wrap(row_wrap)
  );

  // phase*M2 kept as a running sum that tracks the phase counter step for step.
  always_ff @(posedge clk) begin
    if (rst || start_acc) begin
      phase_off <= '0;
    end else if (phase_en) begin
      phase_off <= phase_wrap ? '0 : phase_off + ADDR_W'(m2_q);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      buf_sel <= 1'b0;
    end else if (state == DONE && NBUF == 2) begin
      buf_sel <= ~buf_sel;
    end
  end

  assign base = buf_sel ? ADDR_W'(BUF_OFFSET) : '0;

  // Registered write port; address uses the counters as they were at the fire.
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_en_q   <= 1'b0;
      wr_addr_q <= '0;
      act_q     <= '0;
    end else begin
      wr_en_q <= fire;
      act_q   <= fire ? (N2'(1) << col_v) : '0;
      if (fire) wr_addr_q <= base + ADDR_W'(row_v) + phase_off;
    end
  end

  assign bus.wr_en      = wr_en_q;
  assign bus.wr_addr_B  = wr_addr_q;
  assign bus.activate_B = act_q;

endmodule
